la_sram_wr_ctrl: RTL and testbench

Downstream stage of the logic-analyzer RLE compressor. It consumes the compressor's sample byte, run-length byte and address-count-enable strobe. It writes each accepted word into external SRAM as a circular buffer, and manages arming, pre-trigger fill, trigger capture and post-trigger countdown. Its outputs drive the SRAM address/data/WE pins and the status registers read by the MCU interface.

---
 rtl/la_pkg.sv | 17 +
 rtl/la_addr_counter.sv | 37 +++
 rtl/la_sram_wr_ctrl.sv | 151 +++++++++++++++
 tb/tb_la_sram_wr_ctrl.sv | 471 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared types and default widths for the logic-analyzer
// SRAM write controller.
package la_pkg;

  localparam int LA_ADDR_W = 19;
  localparam int LA_DATA_W = 8;
  localparam int LA_CNT_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    ARMED,
    POST,
    DONE_ST
  } la_state_e;

endpackage

// File: rtl/la_addr_counter.sv
// Modulo-2**ADDR_W SRAM address counter with clear and a
// sticky wrap flag. nxt is the address the next write lands on.
module la_addr_counter
  import la_pkg::*;
#(
  parameter int ADDR_W = LA_ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] nxt,
  output logic              wrapped
);

  // address after the current write cycle completes
  always_comb begin
    nxt = addr + ADDR_W'(inc);
  end

  // address register; wrap flag sets on all-ones -> 0
  always_ff @(posedge CLK) begin
    if (RESET) begin
      addr    <= '0;
      wrapped <= 1'b0;
    end else if (clr) begin
      addr    <= '0;
      wrapped <= 1'b0;
    end else if (inc) begin
      addr <= nxt;
      if (&addr)
        wrapped <= 1'b1;
    end
  end

endmodule

// File: rtl/la_sram_wr_ctrl.sv
// Circular-buffer SRAM writer with pre/post-trigger control.
// Optional LA_FORCE_TRIG_EN adds a FORCE_TRIG input.
module la_sram_wr_ctrl
  import la_pkg::*;
#(
  parameter int ADDR_W = LA_ADDR_W,
  parameter int DATA_W = LA_DATA_W,
  parameter int CNT_W  = LA_CNT_W
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    START,
  input  logic [ADDR_W-1:0]       PRE_TRIG_LEN,
  input  logic [ADDR_W-1:0]       POST_TRIG_LEN,
  input  logic                    TRIG,
`ifdef LA_FORCE_TRIG_EN
  input  logic                    FORCE_TRIG,
`endif
  input  logic [DATA_W-1:0]       LA_DATA_IN,
  input  logic [CNT_W-1:0]        LA_RLE_IN,
  input  logic                    LA_WR_STB,
  output logic [ADDR_W-1:0]       SRAM_ADDR,
  output logic [DATA_W+CNT_W-1:0] SRAM_DATA,
  output logic                    SRAM_WE_N,
  output logic                    BUSY,
  output logic                    DONE,
  output logic                    WRAPPED,
  output logic [ADDR_W-1:0]       TRIG_ADDR
);

  la_state_e         state;
  la_state_e         state_nxt;
  logic [ADDR_W-1:0] pre_len_q;
  logic [ADDR_W-1:0] post_len_q;
  logic [ADDR_W-1:0] pre_cnt;
  logic [ADDR_W-1:0] post_cnt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [ADDR_W:0]   pre_sum;
  logic [ADDR_W:0]   post_sum;
  logic              acc;
  logic              start_go;
  logic              fire;
  logic              fire_done;

  la_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr (
    .CLK     (CLK),
    .RESET   (RESET),
    .clr     (start_go),
    .inc     (!SRAM_WE_N),
    .addr    (SRAM_ADDR),
    .nxt     (addr_nxt),
    .wrapped (WRAPPED)
  );

  // write acceptance, trigger qualification, count sums
  always_comb begin
    acc = LA_WR_STB &&
          (state inside {PREFILL, ARMED, POST});
    start_go = START &&
               (state inside {IDLE, DONE_ST});
`ifdef LA_FORCE_TRIG_EN
    fire = ((state == ARMED) && (TRIG || FORCE_TRIG)) ||
           ((state == PREFILL) && FORCE_TRIG);
`else
    fire = (state == ARMED) && TRIG;
`endif
    pre_sum  = {1'b0, pre_cnt} + {{ADDR_W{1'b0}}, acc};
    post_sum = {1'b0, post_cnt} + {{ADDR_W{1'b0}}, acc};
    fire_done = {{ADDR_W{1'b0}}, acc} >= {1'b0, post_len_q};
  end

  // state register
  always_ff @(posedge CLK) begin
    if (RESET)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start_go)
          state_nxt = PREFILL;
      end
      PREFILL: begin
        if (fire)
          state_nxt = fire_done ? DONE_ST : POST;
        else if (pre_sum >= {1'b0, pre_len_q})
          state_nxt = ARMED;
      end
      ARMED: begin
        if (fire)
          state_nxt = fire_done ? DONE_ST : POST;
      end
      POST: begin
        if (post_sum >= {1'b0, post_len_q})
          state_nxt = DONE_ST;
      end
      DONE_ST: begin
        if (start_go)
          state_nxt = PREFILL;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // status outputs
  always_comb begin
    BUSY = state inside {PREFILL, ARMED, POST};
    DONE = (state == DONE_ST);
  end

  // SRAM strobe/data, length capture, counters, trigger address
  always_ff @(posedge CLK) begin
    if (RESET) begin
      SRAM_WE_N  <= 1'b1;
      SRAM_DATA  <= '0;
      pre_len_q  <= '0;
      post_len_q <= '0;
      pre_cnt    <= '0;
      post_cnt   <= '0;
      TRIG_ADDR  <= '0;
    end else begin
      SRAM_WE_N <= !acc;
      if (acc)
        SRAM_DATA <= {LA_RLE_IN, LA_DATA_IN};
      if (start_go) begin
        pre_len_q  <= PRE_TRIG_LEN;
        post_len_q <= POST_TRIG_LEN;
        pre_cnt    <= '0;
        post_cnt   <= '0;
        TRIG_ADDR  <= '0;
      end else begin
        if ((state == PREFILL) && acc && !fire)
          pre_cnt <= pre_sum[ADDR_W-1:0];
        if (fire) begin
          post_cnt  <= {{(ADDR_W-1){1'b0}}, acc};
          TRIG_ADDR <= addr_nxt;
        end else if ((state == POST) && acc) begin
          post_cnt <= post_sum[ADDR_W-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_la_sram_wr_ctrl.sv
// Directed bench for la_sram_wr_ctrl: a default-width
// instance plus a 4-bit-address instance for wrap checks.
module tb_la_sram_wr_ctrl;

  logic        CLK;
  logic        RESET;
  logic        START;
  logic        TRIG;
  logic        LA_WR_STB;
  logic [18:0] pre_len;
  logic [18:0] post_len;
  logic [7:0]  din;
  logic [7:0]  rle;
`ifdef LA_FORCE_TRIG_EN
  logic        force_trig;
`endif

  logic [18:0] b_addr;
  logic [15:0] b_data;
  logic        b_we_n;
  logic        b_busy;
  logic        b_done;
  logic        b_wrap;
  logic [18:0] b_taddr;

  logic [3:0]  s_addr;
  logic [15:0] s_data;
  logic        s_we_n;
  logic        s_busy;
  logic        s_done;
  logic        s_wrap;
  logic [3:0]  s_taddr;

  int n_tests;
  int n_fail;
  int nwr;
  int swr;
  int last;

  la_sram_wr_ctrl u_dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .START         (START),
    .PRE_TRIG_LEN  (pre_len),
    .POST_TRIG_LEN (post_len),
    .TRIG          (TRIG),
`ifdef LA_FORCE_TRIG_EN
    .FORCE_TRIG    (force_trig),
`endif
    .LA_DATA_IN    (din),
    .LA_RLE_IN     (rle),
    .LA_WR_STB     (LA_WR_STB),
    .SRAM_ADDR     (b_addr),
    .SRAM_DATA     (b_data),
    .SRAM_WE_N     (b_we_n),
    .BUSY          (b_busy),
    .DONE          (b_done),
    .WRAPPED       (b_wrap),
    .TRIG_ADDR     (b_taddr)
  );

  la_sram_wr_ctrl #(
    .ADDR_W (4)
  ) u_small (
    .CLK           (CLK),
    .RESET         (RESET),
    .START         (START),
    .PRE_TRIG_LEN  (pre_len[3:0]),
    .POST_TRIG_LEN (post_len[3:0]),
    .TRIG          (TRIG),
`ifdef LA_FORCE_TRIG_EN
    .FORCE_TRIG    (force_trig),
`endif
    .LA_DATA_IN    (din),
    .LA_RLE_IN     (rle),
    .LA_WR_STB     (LA_WR_STB),
    .SRAM_ADDR     (s_addr),
    .SRAM_DATA     (s_data),
    .SRAM_WE_N     (s_we_n),
    .BUSY          (s_busy),
    .DONE          (s_done),
    .WRAPPED       (s_wrap),
    .TRIG_ADDR     (s_taddr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic arm(input int pre, input int post);
    pre_len  = 19'(pre);
    post_len = 19'(post);
    START = 1'b1;
    tick();
    START = 1'b0;
    nwr  = 0;
    swr  = 0;
    last = -1;
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    START = 1'b0;
    TRIG = 1'b0;
    LA_WR_STB = 1'b0;
    pre_len = '0;
    post_len = '0;
    din = '0;
    rle = '0;
`ifdef LA_FORCE_TRIG_EN
    force_trig = 1'b0;
`endif
    tick();
    tick();
    RESET = 1'b0;
    n_tests++;
    if (b_addr !== 19'd0) begin
      n_fail++;
      $display("FAIL rst_addr got %0h want 0", b_addr);
    end
    n_tests++;
    if (b_data !== 16'd0) begin
      n_fail++;
      $display("FAIL rst_data got %0h want 0", b_data);
    end
    n_tests++;
    if (b_we_n !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_we_n got %b want 1", b_we_n);
    end
    n_tests++;
    if ({b_busy, b_done, b_wrap} !== 3'b000) begin
      n_fail++;
      $display("FAIL rst_flags got %b want 000",
               {b_busy, b_done, b_wrap});
    end
    n_tests++;
    if (b_taddr !== 19'd0) begin
      n_fail++;
      $display("FAIL rst_taddr got %0h want 0", b_taddr);
    end
  endtask

  task automatic test_basic();
    arm(4, 3);
    n_tests++;
    if (b_busy !== 1'b1 || b_we_n !== 1'b1) begin
      n_fail++;
      $display("FAIL arm_busy got busy=%b we_n=%b want 1 1",
               b_busy, b_we_n);
    end
    for (int k = 0; k < 15; k++) begin
      LA_WR_STB = 1'b1;
      TRIG  = (k == 6);
      START = (k == 5);
      din = (k == 0) ? 8'hA5 : 8'(k);
      rle = (k == 0) ? 8'h07 : 8'(8'h10 + k);
      tick();
      if (k == 0) begin
        n_tests++;
        if (b_we_n !== 1'b0) begin
          n_fail++;
          $display("FAIL basic_latency got we_n=%b want 0",
                   b_we_n);
        end
      end
      if (b_we_n === 1'b0) begin
        n_tests++;
        if (b_addr !== 19'(nwr)) begin
          n_fail++;
          $display("FAIL basic_waddr got %0d want %0d",
                   b_addr, nwr);
        end
        if (nwr == 0) begin
          n_tests++;
          if (b_data !== 16'h07A5) begin
            n_fail++;
            $display("FAIL basic_data got %h want 07a5",
                     b_data);
          end
        end
        nwr++;
      end
    end
    LA_WR_STB = 1'b0;
    TRIG = 1'b0;
    START = 1'b0;
    tick();
    n_tests++;
    if (nwr != 9) begin
      n_fail++;
      $display("FAIL basic_nwr got %0d want 9", nwr);
    end
    n_tests++;
    if (b_addr !== 19'd9) begin
      n_fail++;
      $display("FAIL basic_addr got %0d want 9", b_addr);
    end
    n_tests++;
    if (b_done !== 1'b1 || b_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done got done=%b busy=%b want 1 0",
               b_done, b_busy);
    end
    n_tests++;
    if (b_taddr !== 19'd6) begin
      n_fail++;
      $display("FAIL basic_taddr got %0d want 6", b_taddr);
    end
    n_tests++;
    if (b_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_wrap got %b want 0", b_wrap);
    end
  endtask

  task automatic test_trig_prefill();
    arm(10, 2);
    for (int k = 0; k < 20; k++) begin
      LA_WR_STB = 1'b1;
      TRIG = (k <= 9) || (k == 12);
      din = 8'(k);
      rle = 8'd1;
      tick();
      if (b_we_n === 1'b0)
        nwr++;
      if (k == 11) begin
        n_tests++;
        if (b_busy !== 1'b1 || b_done !== 1'b0) begin
          n_fail++;
          $display("FAIL pre_ignore got busy=%b done=%b want 1 0",
                   b_busy, b_done);
        end
      end
    end
    LA_WR_STB = 1'b0;
    TRIG = 1'b0;
    tick();
    n_tests++;
    if (b_taddr !== 19'd12) begin
      n_fail++;
      $display("FAIL pre_taddr got %0d want 12", b_taddr);
    end
    n_tests++;
    if (nwr != 14 || b_addr !== 19'd14) begin
      n_fail++;
      $display("FAIL pre_count got nwr=%0d addr=%0d want 14 14",
               nwr, b_addr);
    end
    n_tests++;
    if (b_done !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_done got %b want 1", b_done);
    end
  endtask

  task automatic test_same_cycle();
    arm(5, 1);
    for (int k = 0; k < 9; k++) begin
      LA_WR_STB = 1'b1;
      TRIG = (k == 5);
      tick();
      if (b_we_n === 1'b0) begin
        nwr++;
        last = int'(b_addr);
      end
      if (k == 5) begin
        n_tests++;
        if (b_done !== 1'b1) begin
          n_fail++;
          $display("FAIL same_done got %b want 1", b_done);
        end
      end
    end
    LA_WR_STB = 1'b0;
    TRIG = 1'b0;
    tick();
    n_tests++;
    if (nwr != 6 || last != 5) begin
      n_fail++;
      $display("FAIL same_writes got n=%0d last=%0d want 6 5",
               nwr, last);
    end
    n_tests++;
    if (b_taddr !== 19'd5) begin
      n_fail++;
      $display("FAIL same_taddr got %0d want 5", b_taddr);
    end
    n_tests++;
    if (b_addr !== 19'd6) begin
      n_fail++;
      $display("FAIL same_addr got %0d want 6", b_addr);
    end
  endtask

  task automatic test_post_zero();
    arm(2, 0);
    for (int k = 0; k < 6; k++) begin
      LA_WR_STB = (k < 2);
      TRIG = (k == 3);
      tick();
      if (b_we_n === 1'b0)
        nwr++;
      if (k == 3) begin
        n_tests++;
        if (b_done !== 1'b1) begin
          n_fail++;
          $display("FAIL post0_done got %b want 1", b_done);
        end
      end
    end
    TRIG = 1'b0;
    n_tests++;
    if (nwr != 2 || b_addr !== 19'd2) begin
      n_fail++;
      $display("FAIL post0_addr got n=%0d addr=%0d want 2 2",
               nwr, b_addr);
    end
    n_tests++;
    if (b_taddr !== 19'd2) begin
      n_fail++;
      $display("FAIL post0_taddr got %0d want 2", b_taddr);
    end
  endtask

  task automatic test_pre_zero();
    arm(0, 1);
    for (int k = 0; k < 5; k++) begin
      LA_WR_STB = (k == 1);
      TRIG = (k == 1);
      tick();
      if (b_we_n === 1'b0) begin
        nwr++;
        last = int'(b_addr);
      end
    end
    LA_WR_STB = 1'b0;
    TRIG = 1'b0;
    n_tests++;
    if (nwr != 1 || last != 0) begin
      n_fail++;
      $display("FAIL pre0_write got n=%0d last=%0d want 1 0",
               nwr, last);
    end
    n_tests++;
    if (b_done !== 1'b1 || b_taddr !== 19'd0) begin
      n_fail++;
      $display("FAIL pre0_done got done=%b taddr=%0d want 1 0",
               b_done, b_taddr);
    end
  endtask

  task automatic test_wrap();
    arm(12, 4);
    for (int k = 0; k < 26; k++) begin
      LA_WR_STB = 1'b1;
      TRIG = (k == 18);
      tick();
      if (s_we_n === 1'b0)
        swr++;
      if (k == 15) begin
        n_tests++;
        if (s_addr !== 4'd15 || s_wrap !== 1'b0) begin
          n_fail++;
          $display("FAIL wrap_pre got addr=%0d wrap=%b want 15 0",
                   s_addr, s_wrap);
        end
      end
      if (k == 16) begin
        n_tests++;
        if (s_addr !== 4'd0 || s_wrap !== 1'b1) begin
          n_fail++;
          $display("FAIL wrap_edge got addr=%0d wrap=%b want 0 1",
                   s_addr, s_wrap);
        end
      end
    end
    LA_WR_STB = 1'b0;
    TRIG = 1'b0;
    n_tests++;
    if (swr != 22 || s_done !== 1'b1) begin
      n_fail++;
      $display("FAIL wrap_count got n=%0d done=%b want 22 1",
               swr, s_done);
    end
    n_tests++;
    if (s_taddr !== 4'd2 || s_addr !== 4'd6) begin
      n_fail++;
      $display("FAIL wrap_small got taddr=%0d addr=%0d want 2 6",
               s_taddr, s_addr);
    end
    n_tests++;
    if (b_taddr !== 19'd18 || b_addr !== 19'd22 ||
        b_wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_big got t=%0d a=%0d w=%b want 18 22 0",
               b_taddr, b_addr, b_wrap);
    end
  endtask

  task automatic test_reset_mid_post();
    arm(1, 10);
    for (int k = 0; k < 4; k++) begin
      LA_WR_STB = 1'b1;
      TRIG = (k == 1);
      din = 8'h3C;
      tick();
    end
    TRIG = 1'b0;
    n_tests++;
    if (b_busy !== 1'b1 || b_we_n !== 1'b0) begin
      n_fail++;
      $display("FAIL midpost_busy got busy=%b we_n=%b want 1 0",
               b_busy, b_we_n);
    end
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if ({b_we_n, b_addr, b_busy, b_done} !==
          {1'b1, 19'd0, 1'b0, 1'b0}) begin
        n_fail++;
        $display("FAIL midpost_rst got we_n=%b a=%0d b=%b d=%b",
                 b_we_n, b_addr, b_busy, b_done);
      end
    end
    n_tests++;
    if (b_data !== 16'd0 || b_taddr !== 19'd0) begin
      n_fail++;
      $display("FAIL midpost_regs got data=%h taddr=%0d want 0 0",
               b_data, b_taddr);
    end
    RESET = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (b_we_n !== 1'b1 || b_busy !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_stb got we_n=%b busy=%b want 1 0",
                 b_we_n, b_busy);
      end
    end
    LA_WR_STB = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_basic();
    test_trig_prefill();
    test_same_cycle();
    test_post_zero();
    test_pre_zero();
    test_wrap();
    test_reset_mid_post();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
